gabor_conv3x3_mac: RTL
======================

// Module: gabor_conv3x3_mac
// PURPOSE
//  Sequencer + MAC for one 3x3 Gabor tap set. On start it walks kernel_addr 0..8 into the combinational
//  kernel ROM, converts each IEEE-754 single coefficient to signed fixed point, multiplies by the
//  matching pixel of a latched 3x3 window and accumulates. Sits directly downstream of the kernel ROM
//  and upstream of the output/pixel-writeback stage.
// PARAMETERS
//  FRAC_BITS  24  fraction bits of converted coefficient (coef = round-toward-zero(val * 2^FRAC_BITS))
//  COEF_W     32  signed width of converted coefficient
//  PIX_W      8   unsigned pixel width
//  ACC_W      48  signed accumulator / result width
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            synchronous active-low reset
//  start        in   1            request one convolution; sampled only when busy==0
//  pix_window   in   9*PIX_W      pixel k (row-major, k=0..8) at pix_window[PIX_W*k +: PIX_W]
//  kernel_addr  out  4            ROM address, 0..8 only
//  kernel_val   in   32           IEEE-754 single from ROM, same-cycle (combinational) response
//  busy         out  1            operation in progress
//  done         out  1            1-cycle pulse, result valid
//  result       out  ACC_W        signed sum(coef_k * pix_k), scaled by 2^FRAC_BITS; held until next done
//  coef_sat     out  1            valid with done: any coef saturated or was NaN/Inf in this run
// BEHAVIOUR
//  Reset (rst_n==0 at edge): state=IDLE, kernel_addr=0, busy=0, done=0, result=0, coef_sat=0, acc=0. Reset wins
//  over start. Reset mid-run aborts: no done, result returns to 0.
//  FSM: IDLE -> RUN (start && !busy) ; RUN k=0..8, one tap per cycle ; RUN(k==8) -> DRAIN ; DRAIN -> IDLE.
//  Edge E0 samples start: latch pix_window, clear acc and sat flag, k=0, busy=1.
//  RUN: kernel_addr=k; fp32_to_fixed(kernel_val) * zero-extended pix_k registered as prod at the
//  following edge (stage 1). acc += prod one edge later (stage 2). Product of tap k is registered at edge
//  E(k+1) and accumulated at E(k+2).
//  DRAIN (one cycle): at edge E10, result<=acc+prod(tap 8), coef_sat<=sticky flag, done<=1, busy<=0,
//  state<=IDLE. done is high for exactly the cycle after E10; latency = 10 edges from start sampling.
//  Back-to-back: start asserted during the done cycle is accepted (busy already 0). start while busy ignored.
//  kernel_addr=0 in IDLE and DRAIN; addresses 9..15 never issued.
//  Conversion: e=val[30:23], m={1'b1,val[22:0]}, sh=e-150+FRAC_BITS.
//   e==0 -> 0 (denormals flushed). e==255 -> +/-(2^(COEF_W-1)-1) by sign, set sat.
//   sh>=0: m<<sh; if magnitude exceeds 2^(COEF_W-1)-1 saturate, set sat. sh<0: m>>(-sh) (0 when -sh>=24).
//   Truncate magnitude, then negate if val[31] (round toward zero, symmetric).
//  Widths: product COEF_W+PIX_W+1 signed; 9-term sum fits ACC_W=48 with no overflow; no acc saturation.
// STRUCTURE
//  gabor_pkg: NUM_TAPS=9, FP32 field positions / bias (127) / mantissa width (23), FSM state encoding.
//  Sub-module fp32_to_fixed (combinational, params FRAC_BITS, COEF_W; out coef, sat).
//  Top: FSM, tap counter, window latch, product register, accumulator, output registers.
// TESTING
//  1 Kernel ROM, pixel0=100, rest 0 -> converted coef0=83886, done after 10 edges, result=8388600, sat=0.
//  2 Kernel ROM, all pixels 255 -> coefs {83886,170,0,1,0,0,0,0,0}, result=21434535; kernel_addr seq 0..8.
//  3 Stub ROM 0xBF800000 (-1.0) all taps, all pixels 1 -> result=-150994944 (-9*2^24), sat=0.
//  4 Stub ROM 0x7FC00000 (NaN) at addr 4, pixel4=2, rest 0 -> result=2*(2^31-1)=4294967294, sat=1.
//  5 start held high 3 runs -> done pulses every 11 cycles; start pulse mid-run ignored, result unchanged.
//  6 rst_n low at RUN k=5 -> busy=0, result=0, no done; next start gives correct result.

Source files
------------

// File: rtl/gabor_pkg.sv
// Shared constants for the 3x3 Gabor MAC: tap count, FP32 field layout and FSM encoding.
// Combinational helpers only; no latency and no flow control.
package gabor_pkg;

  localparam int NUM_TAPS  = 9;
  localparam int TAP_IDX_W = 4;

  localparam int FP32_W        = 32;
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_MAN_W    = 23;
  localparam int FP32_BIAS     = 127;
  localparam int FP32_EXP_MAX  = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } mac_state_e;

  function automatic logic [TAP_IDX_W-1:0] last_tap();
    return TAP_IDX_W'(NUM_TAPS - 1);
  endfunction

endpackage

// File: rtl/fp32_to_fixed.sv
// IEEE-754 single to signed fixed point, round toward zero, symmetric saturation.
// Purely combinational; denormals flush to zero, NaN/Inf saturate by sign.
module fp32_to_fixed
  import gabor_pkg::*;
#(
  parameter int FRAC_BITS = 24,
  parameter int COEF_W    = 32
) (
  input  logic [FP32_W-1:0]        val,
  output logic signed [COEF_W-1:0] coef,
  output logic                     sat
);

  localparam int MANT_W = FP32_MAN_W + 1;
  localparam int WIDE_W = COEF_W + MANT_W;
  localparam logic [COEF_W-1:0] MAG_MAX = {1'b0, {(COEF_W-1){1'b1}}};

  logic                    sign_bit;
  logic [7:0]              exp_f;
  logic [MANT_W-1:0]       mant;
  logic signed [10:0]      sh;
  logic [10:0]             nsh;
  logic [WIDE_W-1:0]       wide;
  logic [COEF_W-1:0]       mag;

  always_comb begin
    sign_bit = val[FP32_SIGN_BIT];
    exp_f    = val[FP32_EXP_MSB:FP32_EXP_LSB];
    mant     = {1'b1, val[FP32_MAN_W-1:0]};
    sh       = $signed({3'b000, exp_f}) - $signed(11'(FP32_BIAS + FP32_MAN_W))
               + $signed(11'(FRAC_BITS));
    nsh      = 11'(-sh);
    wide     = '0;
    mag      = '0;
    sat      = 1'b0;

    if (exp_f == 8'd0) begin
      mag = '0;
    end else if (exp_f == 8'(FP32_EXP_MAX)) begin
      mag = MAG_MAX;
      sat = 1'b1;
    end else if (!sh[10]) begin
      // Any left shift of COEF_W or more cannot fit; otherwise check the widened value.
      if (sh[9:0] >= 10'(COEF_W)) begin
        mag = MAG_MAX;
        sat = 1'b1;
      end else begin
        wide = WIDE_W'(mant) << sh[5:0];
        if (wide > WIDE_W'(MAG_MAX)) begin
          mag = MAG_MAX;
          sat = 1'b1;
        end else begin
          mag = wide[COEF_W-1:0];
        end
      end
    end else begin
      if (nsh >= 11'(MANT_W)) begin
        mag = '0;
      end else begin
        mag = COEF_W'(mant >> nsh[4:0]);
      end
    end

    coef = sign_bit ? -$signed(mag) : $signed(mag);
  end

endmodule

// File: rtl/gabor_conv3x3_mac.sv
// Sequencer + MAC for one 3x3 Gabor tap set: walks the kernel ROM, converts, multiplies, accumulates.
// Latency 10 edges from accepted start to done; start is ignored while busy (no other backpressure).
module gabor_conv3x3_mac
  import gabor_pkg::*;
#(
  parameter int FRAC_BITS = 24,
  parameter int COEF_W    = 32,
  parameter int PIX_W     = 8,
  parameter int ACC_W     = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_TAPS*PIX_W-1:0]  pix_window,
  output logic [TAP_IDX_W-1:0]       kernel_addr,
  input  logic [FP32_W-1:0]          kernel_val,
  output logic                       busy,
  output logic                       done,
  output logic signed [ACC_W-1:0]    result,
  output logic                       coef_sat
);

  localparam int PROD_W = COEF_W + PIX_W + 1;

  mac_state_e                  state_q, state_d;
  logic [TAP_IDX_W-1:0]        k_q, k_d;
  logic [NUM_TAPS*PIX_W-1:0]   win_q, win_d;
  logic signed [PROD_W-1:0]    prod_q, prod_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic                        sat_q, sat_d;
  logic signed [ACC_W-1:0]     result_q, result_d;
  logic                        coef_sat_q, coef_sat_d;
  logic                        done_q, done_d;

  logic signed [COEF_W-1:0]    coef;
  logic                        conv_sat;
  logic [PIX_W-1:0]            win_pix [NUM_TAPS];
  logic [PIX_W-1:0]            pix_k;
  logic signed [PROD_W-1:0]    tap_prod;
  logic signed [ACC_W-1:0]     acc_plus_prod;

  fp32_to_fixed #(
    .FRAC_BITS (FRAC_BITS),
    .COEF_W    (COEF_W)
  ) u_conv (
    .val  (kernel_val),
    .coef (coef),
    .sat  (conv_sat)
  );

  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      win_pix[i] = win_q[PIX_W*i +: PIX_W];
    end
    pix_k         = (k_q < TAP_IDX_W'(NUM_TAPS)) ? win_pix[k_q] : '0;
    tap_prod      = PROD_W'(coef) * PROD_W'($signed({1'b0, pix_k}));
    acc_plus_prod = acc_q + ACC_W'(prod_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      win_q      <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      result_q   <= '0;
      coef_sat_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      win_q      <= win_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      result_q   <= result_d;
      coef_sat_q <= coef_sat_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (k_q == last_tap()) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Two-stage pipe: product of tap k registers one edge after its address, then joins acc.
  always_comb begin
    k_d        = k_q;
    win_d      = win_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    result_d   = result_q;
    coef_sat_d = coef_sat_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          win_d  = pix_window;
          acc_d  = '0;
          prod_d = '0;
          sat_d  = 1'b0;
          k_d    = '0;
        end
      end
      ST_RUN: begin
        prod_d = tap_prod;
        acc_d  = acc_plus_prod;
        sat_d  = sat_q | conv_sat;
        k_d    = (k_q == last_tap()) ? '0 : k_q + 1'b1;
      end
      ST_DRAIN: begin
        result_d   = acc_plus_prod;
        coef_sat_d = sat_q;
        done_d     = 1'b1;
        k_d        = '0;
      end
      default: begin
        k_d = '0;
      end
    endcase
  end

  always_comb begin
    kernel_addr = (state_q == ST_RUN) ? k_q : '0;
    busy        = (state_q != ST_IDLE);
    done        = done_q;
    result      = result_q;
    coef_sat    = coef_sat_q;
  end

  a_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
    kernel_addr < TAP_IDX_W'(NUM_TAPS));
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !busy);

endmodule
